// File: rtl/snn_pkg.sv
// Shared SNN core definitions: neuron/sensor indexing used by the front end and core.
package snn_pkg;

  localparam int NUM_NEURONS   = 16;
  localparam int NEURON_ADDR_W = $clog2(NUM_NEURONS);

  typedef logic [NEURON_ADDR_W-1:0] neuron_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter
  import snn_pkg::*;
#(
  parameter  int N = NUM_NEURONS,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] idx_s;
  logic         found_s;

  // Scan N positions starting at ptr; index arithmetic wraps because N is a power of 2.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = '0;
    for (int i = 0; i < N; i++) begin
      idx_s = ptr + W'(i);
      if (en && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/sensor_event_arbiter.sv
// Sensor front end: coalesces spikes into pending flags, round-robin serialises
// them into a small event FIFO and counts spikes lost to coalescing.
module sensor_event_arbiter
  import snn_pkg::*;
#(
  parameter int NUM_SENSORS = NUM_NEURONS,
  parameter int FIFO_DEPTH  = 8,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_SENSORS-1:0]         sensor_spike,
  input  logic                           event_ack,
  output logic                           event_received,
  output logic [$clog2(NUM_SENSORS)-1:0] event_addr,
  output logic                           fifo_full,
  output logic [DROP_CNT_W-1:0]          drop_count
);

  localparam int ADDR_W = $clog2(NUM_SENSORS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int POP_W  = ADDR_W + 1;
  localparam int SUM_W  = DROP_CNT_W + POP_W;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_CNT_W{1'b1}});

  logic [NUM_SENSORS-1:0] pending_r;
  logic [ADDR_W-1:0]      rr_ptr_r;
  logic [ADDR_W-1:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [DROP_CNT_W-1:0]  drop_r;

  logic [NUM_SENSORS-1:0] grant_s;
  logic [ADDR_W-1:0]      grant_idx_s;
  logic [NUM_SENSORS-1:0] coalesced_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   push_ok_s;
  logic [SUM_W-1:0]       drop_sum_s;
  logic [DROP_CNT_W-1:0]  drop_next_s;

  function automatic logic [POP_W-1:0] count_ones(input logic [NUM_SENSORS-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SENSORS; i++) c = c + POP_W'(v[i]);
    return c;
  endfunction

  // A pop this cycle frees a slot, so a full FIFO can still accept a grant.
  assign pop_s     = event_ack && (count_r != '0);
  assign push_ok_s = (count_r < CNT_W'(FIFO_DEPTH)) || pop_s;
  assign push_s    = |grant_s;

  rr_arbiter #(.N(NUM_SENSORS)) u_arb (
    .req       (pending_r),
    .ptr       (rr_ptr_r),
    .en        (push_ok_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // A spike on the line being granted is not a loss: it simply re-arms the flag.
  assign coalesced_s = sensor_spike & pending_r & ~grant_s;

  // Saturating accumulation of coalesced spikes.
  always_comb begin
    drop_sum_s = SUM_W'(drop_r) + SUM_W'(count_ones(coalesced_s));
    if (drop_sum_s > DROP_MAX) begin
      drop_next_s = '1;
    end else begin
      drop_next_s = drop_sum_s[DROP_CNT_W-1:0];
    end
  end

  // Pending flags, arbiter pointer, FIFO storage/pointers and drop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= '0;
      rr_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      drop_r    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      pending_r <= (pending_r & ~grant_s) | sensor_spike;
      drop_r    <= drop_next_s;
      if (push_s) begin
        mem_r[wr_ptr_r] <= grant_idx_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        rr_ptr_r        <= grant_idx_s + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign event_received = (count_r != '0);
  assign fifo_full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign event_addr     = event_received ? mem_r[rd_ptr_r] : '0;
  assign drop_count     = drop_r;

endmodule

// File: tb/tb_sensor_event_arbiter.sv
// Scoreboard bench: driver updates a queue-based reference model, monitor checks
// head events and status against it each cycle.
module tb_sensor_event_arbiter;

  localparam int NS    = 16;
  localparam int DEPTH = 8;
  localparam int DMAX  = 255;

  logic          clock;
  logic          reset_n;
  logic [NS-1:0] sensor_spike;
  logic          event_ack;
  logic          event_received;
  logic [3:0]    event_addr;
  logic          fifo_full;
  logic [7:0]    drop_count;

  sensor_event_arbiter #(.NUM_SENSORS(NS), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(8)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sensor_spike   (sensor_spike),
    .event_ack      (event_ack),
    .event_received (event_received),
    .event_addr     (event_addr),
    .fifo_full      (fifo_full),
    .drop_count     (drop_count)
  );

  typedef struct packed {
    logic       rec;
    logic       full;
    logic [7:0] drop;
  } stat_t;

  int     vectors = 0;
  int     miscompares = 0;
  bit     checking = 1'b0;
  int     exp_q[$];
  stat_t  stat_q[$];

  bit [NS-1:0] m_pend;
  int          m_ptr;
  int          m_fifo[$];
  int          m_drop;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan pending flags from the pointer, respect FIFO room, count coalesced spikes.
  task automatic model_step(input bit [NS-1:0] sp, input bit ack);
    int  g;
    bit  pop;
    bit  room;
    g    = -1;
    pop  = ack && (m_fifo.size() > 0);
    room = (m_fifo.size() < DEPTH) || pop;
    if (room) begin
      for (int k = 0; k < NS; k++) begin
        if (m_pend[(m_ptr + k) % NS]) begin
          g = (m_ptr + k) % NS;
          break;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (sp[i] && m_pend[i] && i != g) m_drop = (m_drop < DMAX) ? m_drop + 1 : DMAX;
    end
    if (g >= 0) m_pend[g] = 1'b0;
    m_pend = m_pend | sp;
    if (pop) void'(m_fifo.pop_front());
    if (g >= 0) begin
      m_fifo.push_back(g);
      exp_q.push_back(g);
      m_ptr = (g + 1) % NS;
    end
  endtask

  task automatic cycle(input bit [NS-1:0] sp, input bit ack);
    stat_t s;
    @(negedge clock);
    s.rec  = (m_fifo.size() != 0);
    s.full = (m_fifo.size() == DEPTH);
    s.drop = 8'(m_drop);
    stat_q.push_back(s);
    checking     = 1'b1;
    sensor_spike = sp;
    event_ack    = ack;
    model_step(sp, ack);
  endtask

  task automatic do_reset();
    checking     = 1'b0;
    reset_n      = 1'b0;
    sensor_spike = '0;
    event_ack    = 1'b0;
    m_pend = '0;
    m_ptr  = 0;
    m_drop = 0;
    m_fifo.delete();
    exp_q.delete();
    stat_q.delete();
    #1;
    check("rst_event_received", int'(event_received), 0);
    check("rst_event_addr", int'(event_addr), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_drop_count", int'(drop_count), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: status every cycle, head event whenever the DUT presents one.
  always @(negedge clock) begin
    stat_t s;
    #1;
    if (checking) begin
      if (stat_q.size() == 0) begin
        check("status_queue_underflow", 1, 0);
      end else begin
        s = stat_q.pop_front();
        check("event_received", int'(event_received), int'(s.rec));
        check("fifo_full", int'(fifo_full), int'(s.full));
        check("drop_count", int'(drop_count), int'(s.drop));
      end
      if (event_received) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event_addr", int'(event_addr), -1);
        end else begin
          check("event_addr", int'(event_addr), exp_q[0]);
          if (event_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit [NS-1:0] sp;
    reset_n      = 1'b0;
    sensor_spike = '0;
    event_ack    = 1'b0;
    do_reset();

    // Single spike on sensor 5, then pop it.
    cycle(16'h0020, 1'b0);
    repeat (3) cycle(16'h0000, 1'b0);
    cycle(16'h0000, 1'b1);
    repeat (2) cycle(16'h0000, 1'b0);

    // Four simultaneous spikes drain in round-robin order.
    cycle(16'h8421, 1'b0);
    repeat (6) cycle(16'h0000, 1'b0);
    repeat (5) cycle(16'h0000, 1'b1);

    // Fairness between two permanently active sensors.
    repeat (20) cycle(16'h000C, 1'b1);
    repeat (4) cycle(16'h0000, 1'b1);

    // Overflow: nine sensors, eight slots.
    do_reset();
    cycle(16'h01FF, 1'b0);
    repeat (10) cycle(16'h0000, 1'b0);
    cycle(16'h0100, 1'b0);
    cycle(16'h0000, 1'b1);
    repeat (2) cycle(16'h0000, 1'b0);
    repeat (12) cycle(16'h0000, 1'b1);

    // Spike on a line in the very cycle it is granted.
    do_reset();
    cycle(16'h0080, 1'b0);
    cycle(16'h0080, 1'b0);
    repeat (4) cycle(16'h0000, 1'b0);
    repeat (4) cycle(16'h0000, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      sp = NS'($urandom & $urandom & $urandom);
      cycle(sp, ($urandom_range(0, 3) != 0));
    end

    // Saturate the drop counter.
    repeat (30) cycle(16'hFFFF, 1'b0);
    #2;
    check("drop_saturated", int'(drop_count), DMAX);
    repeat (5) cycle(16'hFFFF, 1'b1);

    // Reset mid-stream; nothing may reappear afterwards.
    @(posedge clock);
    #2;
    do_reset();
    repeat (10) cycle(16'h0000, 1'b1);
    for (int n = 0; n < 100; n++) begin
      sp = NS'($urandom & $urandom);
      cycle(sp, ($urandom_range(0, 1) != 0));
    end
    repeat (12) cycle(16'h0000, 1'b1);

    #3;
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sensor_event_arbiter.md
Name: sensor_event_arbiter

Overview:
- Upstream stage of the SNN core. Collects spike pulses from 16 input sensors, coalesces them into per-sensor pending flags, and serialises them with a round-robin arbiter.
- Buffers the resulting 4-bit sensor addresses in a small FIFO.
- Presents them to the core controller as event_received/event_addr. The controller pops each entry with event_ack once that event's weight row has been processed.

Parameters:
- NUM_SENSORS, 16, number of sensor input lines; must be a power of 2.
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, ≥2.
- DROP_CNT_W, 8, width of the saturating dropped-event counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sensor_spike  input  NUM_SENSORS  one-cycle spike pulses, one bit per sensor, synchronous to clock.
- event_ack  input  1  controller pops the head event; ignored when event_received=0.
- event_received  output  1  FIFO non-empty; head event valid.
- event_addr  output  $clog2(NUM_SENSORS)  sensor index of the head event.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- drop_count  output  DROP_CNT_W  saturating count of coalesced (lost) spikes.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the board level):
  - pending=0, rr_ptr=0, FIFO empty (rd/wr pointers 0, count 0), drop_count=0.
  - Outputs during reset: event_received=0, event_addr=0, fifo_full=0.
- Pending register:
  - Next-state rule: pending_next[i] = (pending[i] & ~grant[i]) | sensor_spike[i].
  - A spike arriving on a line in the same cycle that line is granted re-sets its pending bit. It is not lost.
- Coalescing and drop counting:
  - A spike on a line with pending[i]=1 and grant[i]=0 is coalesced.
  - drop_count increments by the number of such lines that cycle and saturates at 2^DROP_CNT_W-1.
  - drop_count never wraps.
- Arbiter:
  - Combinational round-robin over pending. The search starts at index rr_ptr.
  - grant is one-hot or zero.
  - A grant is issued only when push_ok = (count < FIFO_DEPTH) || (event_ack && event_received).
  - On a grant to index g, rr_ptr ← (g+1) mod NUM_SENSORS. With no grant, rr_ptr holds.
- FIFO:
  - Push writes the granted index at wr_ptr. Pop on event_ack && event_received.
  - Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full and when count=1.
  - Pointers wrap modulo FIFO_DEPTH.
  - event_addr = mem[rd_ptr], driven combinationally from the registered head. It is 0 when empty.
- Latency: a spike sampled at edge k sets pending. Grant and push happen at edge k+1. event_received=1 after edge k+1 (2 cycles minimum with an empty FIFO and no contention).
- Throughput: at most one event is granted and one popped per cycle.
- Full FIFO without ack: no grants. Pending bits persist and further spikes on those lines count as drops.
- Reset mid-operation: all pending events and FIFO contents are discarded. No partial event is presented after deassertion.

Decomposition:
- Shared package snn_pkg:
  - NUM_NEURONS=16 and NEURON_ADDR_W=$clog2(NUM_NEURONS), matching the core's neuron indexing.
  - typedef neuron_addr_t (logic [NEURON_ADDR_W-1:0]).
- One sub-module: rr_arbiter (inputs req, ptr, en; output one-hot grant and encoded grant_idx). It is purely combinational.
- The FIFO is inline: it is a distinct depth and a distinct pop contract from the core's output FIFO.

Test Plan:
- Reset, then a single pulse on sensor_spike[5] at cycle 0:
  - event_received=1 and event_addr=5 after 2 edges.
  - event_ack pops it; event_received=0 on the next cycle.
- Pulse on 0x8421 (sensors 0, 5, 10, 15) in one cycle with rr_ptr=0:
  - FIFO receives 0, 5, 10, 15 in order on consecutive cycles.
  - rr_ptr ends at 0.
- Fairness: hold sensors 2 and 3 pulsing every cycle with ack every cycle:
  - Grants alternate 2, 3, 2, 3…
  - drop_count increments by 1 per cycle (the ungranted line).
- Overflow: no ack, pulse 9 distinct sensors, then pulse the still-pending sensor again:
  - FIFO holds 8 entries and fifo_full=1.
  - The 9th sensor stays pending. The re-pulse increments drop_count to 1.
  - One ack lets the 9th enter on the same edge; fifo_full stays 1.
- Grant/spike collision: pulse sensor 7 in the same cycle it is granted:
  - 7 is pushed, pending[7] remains 1, a second 7 is pushed next cycle, and drop_count is unchanged.
- Saturation and reset: force more than 255 drops, then check drop_count=255. Assert reset_n mid-stream and check all outputs are 0 immediately, with no events after release.
